// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_pkg
// Description : Shared FSM state and access-size encodings for the memory
//               arbiter, plus byte-lane helpers for the AXI write channel.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_AWW  = 3'd3,
        ST_B    = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_e;

    // Instruction fetches are always full 32-bit words
    localparam logic [2:0] C_FETCH_ARSIZE = 3'b010;

    function automatic logic [3:0] lane_strobe(input logic [1:0] size,
                                               input logic [1:0] addr_lo);
        logic [3:0] strb;
        case (size_e'(size))
            SIZE_BYTE: strb = 4'b0001 << addr_lo;
            SIZE_HALF: strb = 4'b0011 << {addr_lo[1], 1'b0};
            default:   strb = 4'hf;
        endcase
        return strb;
    endfunction

    function automatic logic [31:0] lane_replicate(input logic [1:0]  size,
                                                   input logic [31:0] data);
        logic [31:0] rep;
        case (size_e'(size))
            SIZE_BYTE: rep = {4{data[7:0]}};
            SIZE_HALF: rep = {2{data[15:0]}};
            default:   rep = data;
        endcase
        return rep;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Arbitrates a fetch port and a load/store port onto a single
//               AXI4 master, one transaction in flight, round-robin on ties.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    input  logic              ex_req,
    input  logic              ex_we,
    input  logic [1:0]        ex_size,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [31:0]       ex_wdata,
    output logic              ex_done,
    output logic [31:0]       rd_data,
    output logic [ADDR_W-1:0] araddr,
    output logic [2:0]        arsize,
    output logic              arvalid,
    input  logic              arready,
    input  logic [31:0]       rdata,
    input  logic              rvalid,
    output logic              rready,
    output logic [ADDR_W-1:0] awaddr,
    output logic [2:0]        awsize,
    output logic              awvalid,
    input  logic              awready,
    output logic [31:0]       wdata,
    output logic [3:0]        wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic              bvalid,
    output logic              bready
);

    state_e            state_q, state_d;
    logic              last_fetch_q, last_fetch_d;
    logic              gnt_ex_q, gnt_ex_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [2:0]        arsize_q, arsize_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic [2:0]        awsize_q, awsize_d;
    logic              awvalid_q, awvalid_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic              wvalid_q, wvalid_d;
    logic              bready_q, bready_d;
    logic [31:0]       rd_data_q, rd_data_d;
    logic              if_done_q, if_done_d;
    logic              ex_done_q, ex_done_d;

    logic w_ex_elig;
    logic w_if_elig;
    logic w_pick_ex;
    logic w_aw_ok;
    logic w_w_ok;

    // A requester still seeing its done pulse has not yet had a chance to drop its request
    assign w_ex_elig = ex_req & ~ex_done_q;
    assign w_if_elig = if_req & ~if_done_q;
    assign w_pick_ex = w_ex_elig & (~w_if_elig | last_fetch_q);

    assign w_aw_ok = ~awvalid_q | awready;
    assign w_w_ok  = ~wvalid_q  | wready;

    always_comb begin
        state_d      = state_q;
        last_fetch_d = last_fetch_q;
        gnt_ex_d     = gnt_ex_q;
        araddr_d     = araddr_q;
        arsize_d     = arsize_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        awaddr_d     = awaddr_q;
        awsize_d     = awsize_q;
        awvalid_d    = awvalid_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        wvalid_d     = wvalid_q;
        bready_d     = bready_q;
        rd_data_d    = rd_data_q;
        if_done_d    = 1'b0;
        ex_done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_ex_elig | w_if_elig) begin
                    gnt_ex_d     = w_pick_ex;
                    last_fetch_d = ~w_pick_ex;
                    if (w_pick_ex && ex_we) begin
                        awaddr_d  = ex_addr;
                        awsize_d  = {1'b0, ex_size};
                        wdata_d   = lane_replicate(ex_size, ex_wdata);
                        wstrb_d   = lane_strobe(ex_size, ex_addr[1:0]);
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = ST_AWW;
                    end else begin
                        araddr_d  = w_pick_ex ? ex_addr : if_addr;
                        arsize_d  = w_pick_ex ? {1'b0, ex_size} : C_FETCH_ARSIZE;
                        arvalid_d = 1'b1;
                        state_d   = ST_AR;
                    end
                end
            end
            ST_AR: begin
                if (arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_R;
                end
            end
            ST_R: begin
                if (rvalid) begin
                    rready_d  = 1'b0;
                    rd_data_d = rdata;
                    if (gnt_ex_q) begin
                        ex_done_d = 1'b1;
                    end else begin
                        if_done_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
            end
            ST_AWW: begin
                // Address and data channels retire independently, in either order
                if (awvalid_q && awready) begin
                    awvalid_d = 1'b0;
                end
                if (wvalid_q && wready) begin
                    wvalid_d = 1'b0;
                end
                if (w_aw_ok && w_w_ok) begin
                    bready_d = 1'b1;
                    state_d  = ST_B;
                end
            end
            ST_B: begin
                if (bvalid) begin
                    bready_d  = 1'b0;
                    ex_done_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_fetch_q <= 1'b1;
            gnt_ex_q     <= 1'b0;
            araddr_q     <= '0;
            arsize_q     <= '0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            awaddr_q     <= '0;
            awsize_q     <= '0;
            awvalid_q    <= 1'b0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            rd_data_q    <= '0;
            if_done_q    <= 1'b0;
            ex_done_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_fetch_q <= last_fetch_d;
            gnt_ex_q     <= gnt_ex_d;
            araddr_q     <= araddr_d;
            arsize_q     <= arsize_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            awaddr_q     <= awaddr_d;
            awsize_q     <= awsize_d;
            awvalid_q    <= awvalid_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            wvalid_q     <= wvalid_d;
            bready_q     <= bready_d;
            rd_data_q    <= rd_data_d;
            if_done_q    <= if_done_d;
            ex_done_q    <= ex_done_d;
        end
    end

    assign if_done = if_done_q;
    assign ex_done = ex_done_q;
    assign rd_data = rd_data_q;
    assign araddr  = araddr_q;
    assign arsize  = arsize_q;
    assign arvalid = arvalid_q;
    assign rready  = rready_q;
    assign awaddr  = awaddr_q;
    assign awsize  = awsize_q;
    assign awvalid = awvalid_q;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign wvalid  = wvalid_q;
    assign bready  = bready_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter with a reactive AXI slave.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int AW = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_req, ex_req, ex_we;
    logic [AW-1:0] if_addr, ex_addr;
    logic [1:0]    ex_size;
    logic [31:0]   ex_wdata;
    logic          if_done, ex_done;
    logic [31:0]   rd_data;
    logic [AW-1:0] araddr, awaddr;
    logic [2:0]    arsize, awsize;
    logic          arvalid, arready, rvalid, rready;
    logic [31:0]   rdata, wdata;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic [3:0]    wstrb;

    int n_tests = 0;
    int n_fail  = 0;

    int          ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
    logic        fixed_en = 1'b0;
    logic [31:0] fixed_val = 32'h0;

    mem_arbiter #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done),
        .ex_req(ex_req), .ex_we(ex_we), .ex_size(ex_size), .ex_addr(ex_addr),
        .ex_wdata(ex_wdata), .ex_done(ex_done), .rd_data(rd_data),
        .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    // ---------------- reactive AXI slave ----------------
    function automatic logic [31:0] slave_word(input logic [AW-1:0] a);
        if (fixed_en) return fixed_val;
        return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    int            ar_cnt, aw_cnt, w_cnt, r_cnt, b_cnt, overlap_cnt;
    logic          aw_got, w_got;
    logic [AW-1:0] last_ar_addr, aw_addr_log;
    logic [2:0]    last_ar_size, aw_size_log;
    logic [31:0]   w_data_log;
    logic [3:0]    w_strb_log;
    logic          aw_hs, w_hs, both_hs;

    assign arready = arvalid && (ar_cnt >= ar_wait);
    assign awready = awvalid && (aw_cnt >= aw_wait);
    assign wready  = wvalid  && (w_cnt  >= w_wait);
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    assign both_hs = (aw_got || aw_hs) && (w_got || w_hs);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ar_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; r_cnt <= 0; b_cnt <= 0;
            rvalid <= 1'b0; bvalid <= 1'b0; rdata <= '0;
            aw_got <= 1'b0; w_got <= 1'b0;
            last_ar_addr <= '0; last_ar_size <= '0;
            aw_addr_log <= '0; aw_size_log <= '0; w_data_log <= '0; w_strb_log <= '0;
            overlap_cnt <= 0;
        end else begin
            ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
            aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
            if (arvalid && arready) begin
                last_ar_addr <= araddr;
                last_ar_size <= arsize;
                rdata        <= slave_word(araddr);
                if (r_wait == 0) rvalid <= 1'b1;
                else r_cnt <= r_wait;
            end else if (r_cnt > 0) begin
                r_cnt <= r_cnt - 1;
                if (r_cnt == 1) rvalid <= 1'b1;
            end
            if (rvalid && rready) rvalid <= 1'b0;
            if (aw_hs) begin aw_addr_log <= awaddr; aw_size_log <= awsize; end
            if (w_hs)  begin w_data_log <= wdata; w_strb_log <= wstrb; end
            if (both_hs) begin
                aw_got <= 1'b0;
                w_got  <= 1'b0;
                if (b_wait == 0) bvalid <= 1'b1;
                else b_cnt <= b_wait;
            end else begin
                if (aw_hs) aw_got <= 1'b1;
                if (w_hs)  w_got  <= 1'b1;
                if (b_cnt > 0) begin
                    b_cnt <= b_cnt - 1;
                    if (b_cnt == 1) bvalid <= 1'b1;
                end
            end
            if (bvalid && bready) bvalid <= 1'b0;
            if ((arvalid || rready) && (awvalid || wvalid || bready)) overlap_cnt <= overlap_cnt + 1;
        end
    end

    // ---------------- reference model: lane rules from plain arithmetic ----------------
    function automatic logic [3:0] exp_strb(input int size, input int addr);
        int lane = addr % 4;
        if (size == 0) return 4'(1 << lane);
        if (size == 1) return 4'(3 << (2 * (lane / 2)));
        return 4'hf;
    endfunction

    function automatic logic [31:0] exp_wdata(input int size, input logic [31:0] d);
        if (size == 0) return 32'(d[7:0]) * 32'h01010101;
        if (size == 1) return 32'(d[15:0]) * 32'h00010001;
        return d;
    endfunction

    task automatic set_waits(input int a, input int r, input int aw, input int w, input int b);
        ar_wait = a; r_wait = r; aw_wait = aw; w_wait = w; b_wait = b;
    endtask

    task automatic do_reset();
        rst = 1'b1; if_req = 1'b0; ex_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; if_req = 1'b0; ex_req = 1'b0; ex_we = 1'b0; ex_size = 2'd0;
        if_addr = '0; ex_addr = '0; ex_wdata = '0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({arvalid, rready, awvalid, wvalid, bready, if_done, ex_done} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_handshakes: got %b required 0000000",
                     {arvalid, rready, awvalid, wvalid, bready, if_done, ex_done});
        end
        n_tests++;
        if (rd_data !== 32'h0 || wstrb !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_data: got rd_data=%h wstrb=%h required 0/0", rd_data, wstrb);
        end
        n_tests++;
        if (araddr !== '0 || awaddr !== '0) begin
            n_fail++;
            $display("FAIL reset_addr: got araddr=%h awaddr=%h required 0/0", araddr, awaddr);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fetch();
        int          done_idx = -1;
        int          pulses = 0;
        logic [31:0] rdv = '0;
        set_waits(0, 0, 0, 0, 0);
        fixed_en = 1'b1; fixed_val = 32'hDEADBEEF;
        if_addr = 15'h0010; if_req = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 0) begin
                n_tests++;
                if (arvalid !== 1'b1 || arsize !== 3'd2 || araddr !== 15'h0010) begin
                    n_fail++;
                    $display("FAIL fetch_ar: got arvalid=%b arsize=%0d araddr=%h required 1/2/0010",
                             arvalid, arsize, araddr);
                end
            end
            if (if_done) begin
                pulses++;
                if (done_idx < 0) begin done_idx = k; rdv = rd_data; end
                if_req = 1'b0;
            end
        end
        // Grant edge, then AR cycle, R cycle, done in the third cycle (index 2)
        n_tests++;
        if (done_idx !== 2) begin
            n_fail++;
            $display("FAIL fetch_latency: got done at cycle %0d required 2", done_idx);
        end
        n_tests++;
        if (rdv !== 32'hDEADBEEF || pulses !== 1) begin
            n_fail++;
            $display("FAIL fetch_data: got rd_data=%h pulses=%0d required deadbeef/1", rdv, pulses);
        end
        fixed_en = 1'b0;
    endtask

    task automatic test_arbitration();
        int order[$];
        int n_ex = 0;
        logic [AW-1:0] first_ar = '1;
        logic [31:0]   rd_seen[$];
        do_reset();
        ex_we = 1'b0; ex_size = 2'd2; ex_addr = 15'h0100;
        if_addr = 15'h0200;
        ex_req = 1'b1; if_req = 1'b1;
        for (int c = 0; c < 80 && order.size() < 3; c++) begin
            @(negedge clk);
            if (arvalid && first_ar === '1) first_ar = araddr;
            if (ex_done) begin
                order.push_back(1); rd_seen.push_back(rd_data);
                n_ex++;
                if (n_ex == 2) ex_req = 1'b0;
            end
            if (if_done) begin
                order.push_back(0); rd_seen.push_back(rd_data);
                if_req = 1'b0;
            end
        end
        ex_req = 1'b0; if_req = 1'b0;
        n_tests++;
        if (first_ar !== 15'h0100) begin
            n_fail++;
            $display("FAIL arb_first_grant: got araddr=%h required 0100", first_ar);
        end
        n_tests++;
        if (order.size() != 3) begin
            n_fail++;
            $display("FAIL arb_count: got %0d completions required 3", order.size());
        end else begin
            n_tests++;
            if (order[0] != 1 || order[1] != 0 || order[2] != 1) begin
                n_fail++;
                $display("FAIL arb_order: got %0d,%0d,%0d required 1,0,1 (1=exec)",
                         order[0], order[1], order[2]);
            end
            n_tests++;
            if (rd_seen[0] !== slave_word(15'h0100) || rd_seen[1] !== slave_word(15'h0200)) begin
                n_fail++;
                $display("FAIL arb_data: got %h/%h required %h/%h", rd_seen[0], rd_seen[1],
                         slave_word(15'h0100), slave_word(15'h0200));
            end
        end
        @(negedge clk);
    endtask

    task automatic test_byte_store();
        int done_idx = -1;
        int pulses = 0;
        set_waits(0, 0, 0, 0, 0);
        ex_we = 1'b1; ex_size = 2'd0; ex_addr = 15'h0003; ex_wdata = 32'h000000AB;
        ex_req = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 0) begin
                n_tests++;
                if (awvalid !== 1'b1 || wvalid !== 1'b1 || wstrb !== 4'b1000 ||
                    wdata !== 32'hABABABAB || awsize !== 3'd0 || awaddr !== 15'h0003) begin
                    n_fail++;
                    $display("FAIL byte_store_aw: got awv=%b wv=%b wstrb=%b wdata=%h awsize=%0d awaddr=%h required 1/1/1000/abababab/0/0003",
                             awvalid, wvalid, wstrb, wdata, awsize, awaddr);
                end
            end
            if (ex_done) begin
                pulses++;
                if (done_idx < 0) done_idx = k;
                ex_req = 1'b0;
            end
        end
        n_tests++;
        if (pulses !== 1 || done_idx !== 2) begin
            n_fail++;
            $display("FAIL byte_store_done: got pulses=%0d at cycle %0d required 1 at 2", pulses, done_idx);
        end
        n_tests++;
        if (w_strb_log !== 4'b1000 || w_data_log !== 32'hABABABAB) begin
            n_fail++;
            $display("FAIL byte_store_slave: got wstrb=%b wdata=%h required 1000/abababab", w_strb_log, w_data_log);
        end
    endtask

    task automatic test_w_delay();
        int aw_drop = -1, w_drop = -1, b_rise = -1, b_while_w = 0, done_idx = -1;
        set_waits(0, 0, 0, 3, 0);
        ex_we = 1'b1; ex_size = 2'd2; ex_addr = 15'h0040; ex_wdata = 32'h11223344;
        ex_req = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (!awvalid && aw_drop < 0) aw_drop = k;
            if (!wvalid && w_drop < 0) w_drop = k;
            if (bready && b_rise < 0) b_rise = k;
            if (bready && wvalid) b_while_w++;
            if (ex_done && done_idx < 0) begin done_idx = k; ex_req = 1'b0; end
        end
        n_tests++;
        if (aw_drop !== 1 || w_drop !== 4) begin
            n_fail++;
            $display("FAIL wdelay_valids: got aw_drop=%0d w_drop=%0d required 1/4", aw_drop, w_drop);
        end
        n_tests++;
        if (b_rise !== 4 || b_while_w !== 0) begin
            n_fail++;
            $display("FAIL wdelay_bready: got rise=%0d overlap=%0d required 4/0", b_rise, b_while_w);
        end
        n_tests++;
        if (done_idx !== 5 || w_data_log !== 32'h11223344 || w_strb_log !== 4'hf) begin
            n_fail++;
            $display("FAIL wdelay_done: got done=%0d wdata=%h wstrb=%h required 5/11223344/f",
                     done_idx, w_data_log, w_strb_log);
        end
        set_waits(0, 0, 0, 0, 0);
    endtask

    task automatic test_reset_mid();
        bit in_r = 1'b0;
        int dones = 0;
        bit ar_seen = 1'b0;
        set_waits(0, 5, 0, 0, 0);
        ex_we = 1'b0; ex_size = 2'd2; ex_addr = 15'h0080; ex_req = 1'b1;
        for (int c = 0; c < 20 && !in_r; c++) begin
            @(negedge clk);
            if (rready) in_r = 1'b1;
        end
        n_tests++;
        if (!in_r) begin
            n_fail++;
            $display("FAIL rstmid_reach_r: got rready never high required 1");
        end
        rst = 1'b1; ex_req = 1'b0;
        #1;
        n_tests++;
        if ({arvalid, rready, awvalid, wvalid, bready, if_done, ex_done} !== 7'b0 ||
            rd_data !== 32'h0 || araddr !== '0 || awaddr !== '0 || wstrb !== 4'h0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got hs=%b rd=%h ar=%h aw=%h strb=%h required all 0",
                     {arvalid, rready, awvalid, wvalid, bready, if_done, ex_done},
                     rd_data, araddr, awaddr, wstrb);
        end
        set_waits(0, 0, 0, 0, 0);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 2) rst = 1'b0;
            if (ex_done || if_done) dones++;
        end
        n_tests++;
        if (dones !== 0) begin
            n_fail++;
            $display("FAIL rstmid_no_done: got %0d done pulses required 0", dones);
        end
        if_addr = 15'h0044; if_req = 1'b1;
        @(negedge clk);
        ar_seen = arvalid && (araddr == 15'h0044);
        n_tests++;
        if (!ar_seen) begin
            n_fail++;
            $display("FAIL rstmid_idle: got arvalid=%b araddr=%h required 1/0044 one cycle after request",
                     arvalid, araddr);
        end
        for (int c = 0; c < 20 && if_req; c++) begin
            @(negedge clk);
            if (if_done) if_req = 1'b0;
        end
        if_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random(input int rounds);
        for (int r = 0; r < rounds; r++) begin
            int ov0;
            set_waits($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
                      $urandom_range(0, 2), $urandom_range(0, 2));
            fixed_en = 1'b0;
            ov0 = overlap_cnt;
            fork
                begin : ex_master
                    logic          we;
                    logic [1:0]    sz;
                    logic [AW-1:0] a;
                    logic [31:0]   d;
                    bit            got;
                    for (int t = 0; t < 12; t++) begin
                        repeat ($urandom_range(0, 2)) @(negedge clk);
                        we = 1'($urandom_range(0, 1));
                        sz = 2'($urandom_range(0, 2));
                        a  = AW'($urandom);
                        d  = $urandom;
                        ex_we = we; ex_size = sz; ex_addr = a; ex_wdata = d; ex_req = 1'b1;
                        got = 1'b0;
                        for (int c = 0; c < 200 && !got; c++) begin
                            @(negedge clk);
                            if (ex_done) got = 1'b1;
                        end
                        ex_req = 1'b0;
                        n_tests++;
                        if (!got) begin
                            n_fail++;
                            $display("FAIL rand_ex_timeout: got no ex_done required one within 200 cycles");
                        end else if (we) begin
                            if (aw_addr_log !== a || aw_size_log !== {1'b0, sz} ||
                                w_strb_log !== exp_strb(int'(sz), int'(a)) ||
                                w_data_log !== exp_wdata(int'(sz), d)) begin
                                n_fail++;
                                $display("FAIL rand_store: got a=%h s=%0d strb=%b d=%h required a=%h s=%0d strb=%b d=%h",
                                         aw_addr_log, aw_size_log, w_strb_log, w_data_log,
                                         a, sz, exp_strb(int'(sz), int'(a)), exp_wdata(int'(sz), d));
                            end
                        end else begin
                            if (rd_data !== slave_word(a) || last_ar_addr !== a ||
                                last_ar_size !== {1'b0, sz}) begin
                                n_fail++;
                                $display("FAIL rand_load: got rd=%h a=%h s=%0d required rd=%h a=%h s=%0d",
                                         rd_data, last_ar_addr, last_ar_size, slave_word(a), a, sz);
                            end
                        end
                    end
                end
                begin : if_master
                    logic [AW-1:0] a;
                    bit            got;
                    for (int t = 0; t < 12; t++) begin
                        repeat ($urandom_range(0, 2)) @(negedge clk);
                        a = AW'($urandom);
                        if_addr = a; if_req = 1'b1;
                        got = 1'b0;
                        for (int c = 0; c < 200 && !got; c++) begin
                            @(negedge clk);
                            if (if_done) got = 1'b1;
                        end
                        if_req = 1'b0;
                        n_tests++;
                        if (!got) begin
                            n_fail++;
                            $display("FAIL rand_if_timeout: got no if_done required one within 200 cycles");
                        end else if (rd_data !== slave_word(a) || last_ar_addr !== a || last_ar_size !== 3'd2) begin
                            n_fail++;
                            $display("FAIL rand_fetch: got rd=%h a=%h s=%0d required rd=%h a=%h s=2",
                                     rd_data, last_ar_addr, last_ar_size, slave_word(a), a);
                        end
                    end
                end
            join
            n_tests++;
            if (overlap_cnt != ov0) begin
                n_fail++;
                $display("FAIL rand_single_inflight: got %0d overlapping cycles required 0", overlap_cnt - ov0);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_arbitration();
        test_byte_store();
        test_w_delay();
        test_reset_mid();
        test_random(3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
